// File: rtl/ov7670_sccb_ctrl.sv
// OV7670 SCCB configuration sequencer: walks the register-init table, issuing one
// 3-phase write per entry. Optional slave-ACK sampling is enabled by OV7670_SCCB_ACK_CHECK_EN.
module ov7670_sccb_ctrl #(
    parameter int         CLK_DIV     = 125,
    parameter logic [7:0] DEV_ADDR    = 8'h42,
    parameter int         RESET_DELAY = 50000,
    parameter int         DELAY_W     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] table_data,
    input  logic        table_done,
    output logic        table_continue,
    output logic        sioc,
    output logic        siod_oe,
    input  logic        siod_in,
    output logic        busy,
    output logic        done,
    output logic        nack
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETTLE   = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_BIT      = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;
    localparam logic [2:0] S_RST_WAIT = 3'd5;
    localparam logic [2:0] S_NEXT     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]         state;
    logic [QW-1:0]      qcnt;
    logic               qt;
    logic               bus_phase;
    logic [1:0]         phase;
    logic [4:0]         bit_cnt;
    logic [26:0]        shreg;
    logic [DELAY_W-1:0] dcnt;
    logic               soft_rst;
    logic               dc_slot;

    assign bus_phase = (state == S_START) || (state == S_BIT) || (state == S_STOP);
    assign qt        = bus_phase && (qcnt == QW'(CLK_DIV - 1));
    // Slots 9, 18 and 27 belong to the slave; the master always releases SIOD there.
    assign dc_slot   = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);

    // Quarter-period divider; parked at zero so every bus phase starts on a full quarter.
    always_ff @(posedge clk) begin
        if (!reset_n || !bus_phase || qt) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt + 1'b1;
        end
    end

    // Table handshake: table_continue is a one-cycle step request; the entry it selects
    // appears on table_data two cycles later, which is what the SETTLE wait covers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            phase          <= 2'd0;
            bit_cnt        <= 5'd0;
            shreg          <= '0;
            dcnt           <= '0;
            soft_rst       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            table_continue <= 1'b0;
        end else begin
            table_continue <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_SETTLE;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        dcnt  <= '0;
                    end
                end
                S_SETTLE: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DELAY_W'(1)) begin
                        dcnt <= '0;
                        if (table_done) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            shreg    <= {DEV_ADDR, 1'b1, table_data[15:8], 1'b1,
                                         table_data[7:0], 1'b1};
                            soft_rst <= (table_data[15:8] == 8'h12) && table_data[7];
                            phase    <= 2'd0;
                            bit_cnt  <= 5'd0;
                            state    <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (qt) begin
                        if (phase == 2'd1) begin
                            phase <= 2'd0;
                            state <= S_BIT;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                S_BIT: begin
                    if (qt) begin
                        phase <= phase + 1'b1;
                        if (phase == 2'd3) begin
                            if (bit_cnt == 5'd26) begin
                                state <= S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shreg   <= {shreg[25:0], 1'b0};
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (qt) begin
                        if (phase == 2'd2) begin
                            phase <= 2'd0;
                            dcnt  <= '0;
                            // A COM7 soft reset needs the sensor to recover before the next write.
                            if (soft_rst) begin
                                state <= S_RST_WAIT;
                            end else begin
                                state          <= S_NEXT;
                                table_continue <= 1'b1;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                S_RST_WAIT: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DELAY_W'(RESET_DELAY - 1)) begin
                        dcnt           <= '0;
                        state          <= S_NEXT;
                        table_continue <= 1'b1;
                    end
                end
                S_NEXT: begin
                    state <= S_SETTLE;
                    dcnt  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pins are registered from the current phase so they never glitch on decode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
        end else begin
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
            case (state)
                S_START: begin
                    sioc    <= (phase == 2'd0);
                    siod_oe <= 1'b1;
                end
                S_BIT: begin
                    sioc    <= (phase == 2'd1) || (phase == 2'd2);
                    siod_oe <= ~shreg[26] & ~dc_slot;
                end
                S_STOP: begin
                    sioc    <= (phase != 2'd0);
                    siod_oe <= (phase != 2'd2);
                end
                default: ;
            endcase
        end
    end

`ifdef OV7670_SCCB_ACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nack <= 1'b0;
        end else if (((state == S_IDLE) || (state == S_DONE)) && start) begin
            nack <= 1'b0;
        end else if ((state == S_BIT) && (phase == 2'd2) && qt && dc_slot && siod_in) begin
            nack <= 1'b1;
        end
    end
`else
    logic unused_siod_in;
    assign unused_siod_in = siod_in;
    assign nack           = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_sccb_ctrl.sv
// Bench for ov7670_sccb_ctrl: table model, SCCB bus decoder with ACKing slave,
// and a byte scoreboard fed when each sequence is started.
module tb_ov7670_sccb_ctrl;

    localparam int CLK_DIV     = 4;
    localparam int RESET_DELAY = 200;
    localparam int TXN_CYC     = 113 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] table_data;
    logic        table_done;
    logic        table_continue;
    logic        sioc;
    logic        siod_oe;
    logic        siod_in;
    logic        busy;
    logic        done;
    logic        nack;

    ov7670_sccb_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .DEV_ADDR   (8'h42),
        .RESET_DELAY(RESET_DELAY),
        .DELAY_W    (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .table_data    (table_data),
        .table_done    (table_done),
        .table_continue(table_continue),
        .sioc          (sioc),
        .siod_oe       (siod_oe),
        .siod_in       (siod_in),
        .busy          (busy),
        .done          (done),
        .nack          (nack)
    );

    always #5 clk = ~clk;

    // Init-table model: step register, then registered data one cycle behind it.
    logic [15:0] tbl [0:15];
    logic [3:0]  tidx;
    always_ff @(posedge clk) begin
        if (!reset_n) tidx <= 4'd0;
        else if (table_continue) tidx <= tidx + 4'd1;
        table_data <= tbl[tidx];
    end
    assign table_done = (table_data == 16'hffff);

    logic slave_pull  = 1'b0;
    logic mon_en      = 1'b0;
    logic nack_inject = 1'b0;
    assign siod_in = ~siod_oe & ~slave_pull;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         gap_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus decoder and slave at the falling clock edge.
    int         cyc = 0;
    int         txn_cnt = 0;
    int         cont_cnt = 0;
    int         byte_cnt = 0;
    int         last_stop = 0;
    int         bitn = 0;
    logic       in_txn = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       m_scl;
    logic       m_sda;
    logic [7:0] shift_r = 8'd0;

    always @(negedge clk) begin
        cyc++;
        m_scl = sioc;
        m_sda = siod_in;
        if (!mon_en) begin
            in_txn     = 1'b0;
            bitn       = 0;
            txn_cnt    = 0;
            cont_cnt   = 0;
            byte_cnt   = 0;
            slave_pull = 1'b0;
            last_stop  = cyc;
            exp_q.delete();
            gap_q.delete();
        end else begin
            if (prev_scl && m_scl && prev_sda && !m_sda) begin
                in_txn = 1'b1;
                bitn   = 0;
            end else if (prev_scl && m_scl && !prev_sda && m_sda && in_txn) begin
                check("stop_bits", bitn, 27);
                in_txn    = 1'b0;
                txn_cnt++;
                last_stop = cyc;
            end else if (!prev_scl && m_scl && in_txn && bitn < 27) begin
                if (bitn % 9 == 8) begin
                    check("dc_release", {31'd0, siod_oe}, 0);
                    check("q_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("byte", shift_r, exp_q.pop_front());
                    byte_cnt++;
                end else begin
                    shift_r = {shift_r[6:0], m_sda};
                end
                bitn++;
            end else if (prev_scl && !m_scl && in_txn) begin
                slave_pull = (bitn % 9 == 8) && !(nack_inject && bitn == 17);
            end
            if (table_continue) begin
                cont_cnt++;
                gap_q.push_back(cyc - last_stop);
            end
        end
        prev_scl = m_scl;
        prev_sda = m_sda;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_table();
        for (int i = 0; i < 16; i++) tbl[i] = 16'hffff;
    endtask

    task automatic new_test();
        reset_n = 1'b0;
        mon_en  = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
    endtask

    task automatic kick(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'h42);
            exp_q.push_back(tbl[i][15:8]);
            exp_q.push_back(tbl[i][7:0]);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_table(input int n, input int budget, output int dur);
        kick(n);
        dur = 1;
        while (!done && dur < budget) begin
            tick();
            dur++;
        end
        check("done_in_time", done, 1);
        check("busy_clear", busy, 0);
        check("sb_drained", exp_q.size(), 0);
    endtask

    int dur_single;
    int dur;
    int k;

    initial begin
        clear_table();
        repeat (3) tick();
        check("rst_sioc", sioc, 1);
        check("rst_siod_oe", siod_oe, 0);
        check("rst_continue", table_continue, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);

        // Single write.
        clear_table();
        tbl[0] = 16'h1101;
        new_test();
        run_table(1, 2000, dur_single);
        check("single_txn", txn_cnt, 1);
        check("single_cont", cont_cnt, 1);
        check("single_dur", (dur_single >= TXN_CYC + 3) && (dur_single <= TXN_CYC + 8), 1);
        check("single_nack", nack, 0);

        // Restart from DONE with the table still exhausted.
        run_table(0, 6, dur);
        check("restart_fast", dur <= 4, 1);
        check("restart_txn", txn_cnt, 1);

        // Full init sequence.
        clear_table();
        tbl[0]  = 16'h1280; tbl[1]  = 16'h1204; tbl[2]  = 16'h1180; tbl[3]  = 16'h0c00;
        tbl[4]  = 16'h3e00; tbl[5]  = 16'h0400; tbl[6]  = 16'h40d0; tbl[7]  = 16'h3a04;
        tbl[8]  = 16'h1438; tbl[9]  = 16'h4fb3; tbl[10] = 16'h50b3; tbl[11] = 16'h5100;
        new_test();
        run_table(12, 20000, dur);
        check("full_txn", txn_cnt, 12);
        check("full_cont", cont_cnt, 12);
        check("full_done", done, 1);

        // Soft-reset delay only after a COM7 reset write.
        clear_table();
        tbl[0] = 16'h1280;
        tbl[1] = 16'h1101;
        new_test();
        run_table(2, 4000, dur);
        check("gap_count", gap_q.size(), 2);
        if (gap_q.size() >= 2) begin
            check("gap_soft_rst", gap_q[0] >= RESET_DELAY, 1);
            check("gap_plain", gap_q[1] < RESET_DELAY, 1);
        end

        // Start while busy is ignored.
        clear_table();
        tbl[0] = 16'h1101;
        new_test();
        fork
            run_table(1, 2000, dur);
            begin
                repeat (40) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        join
        check("busy_start_txn", txn_cnt, 1);
        check("busy_start_dur", dur, dur_single);

        // Reset in the middle of the address byte.
        clear_table();
        tbl[0] = 16'h1101;
        new_test();
        kick(1);
        check("busy_set", busy, 1);
        k = 0;
        while (byte_cnt < 1 && k < 1000) begin
            tick();
            k++;
        end
        check("id_byte_seen", byte_cnt >= 1, 1);
        repeat (3 * 4 * CLK_DIV) tick();
        mon_en  = 1'b0;
        reset_n = 1'b0;
        tick();
        check("midrst_sioc", sioc, 1);
        check("midrst_siod_oe", siod_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_continue", table_continue, 0);
        reset_n = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        tick();
        run_table(1, 2000, dur);
        check("after_rst_txn", txn_cnt, 1);

        // Slave withholds ACK at the second slot.
        clear_table();
        tbl[0] = 16'h1101;
        tbl[1] = 16'h1300;
        new_test();
        nack_inject = 1'b1;
        run_table(2, 4000, dur);
        nack_inject = 1'b0;
        check("nack_txn", txn_cnt, 2);
`ifdef OV7670_SCCB_ACK_CHECK_EN
        check("nack_flag", nack, 1);
`else
        check("nack_flag", nack, 0);
`endif
        run_table(0, 6, dur);
        check("nack_cleared", nack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
